stopwatch_ctrl: RTL and testbench

//   Run/pause/clear/lap controller for the stopwatch. Divides clk down to a
//   1 Hz tick, keeps the elapsed-seconds counter and drives the 13-bit

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_edge.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 109 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_pkg: state type and counter defaults for stopwatch/display |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

  localparam int unsigned CNT_W_DEFAULT     = 13;
  localparam int unsigned MAX_COUNT_DEFAULT = 5999;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/stopwatch_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_edge: single-cycle press detector for a debounced button   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stopwatch_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;

  // History resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) btn_q <= 1'b1;
    else        btn_q <= btn_i;
  end

  assign press_o = btn_i & ~btn_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_ctrl: run/pause/clear/lap control with 1 Hz seconds count  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start_stop,
  input  logic             btn_clear,
  input  logic             btn_lap,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             lap_frozen,
  output logic             tick
);

  localparam int unsigned       PS_W    = $clog2(CLK_HZ);
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0]  SEC_MAX = CNT_W'(MAX_COUNT);

  logic ss_press, clr_press, lap_press;

  stopwatch_edge u_edge_ss  (.clk(clk), .rst_n(rst_n), .btn_i(btn_start_stop), .press_o(ss_press));
  stopwatch_edge u_edge_clr (.clk(clk), .rst_n(rst_n), .btn_i(btn_clear),      .press_o(clr_press));
  stopwatch_edge u_edge_lap (.clk(clk), .rst_n(rst_n), .btn_i(btn_lap),        .press_o(lap_press));

  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] sec_q, sec_d, lap_q, lap_d, sec_inc;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             frozen_q, frozen_d, tick_q, tick_d;

  assign sec_inc = sec_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sec_q    <= '0;
      lap_q    <= '0;
      ps_q     <= '0;
      frozen_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      lap_q    <= lap_d;
      ps_q     <= ps_d;
      frozen_q <= frozen_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    lap_d    = lap_q;
    ps_d     = ps_q;
    frozen_d = frozen_q;
    tick_d   = 1'b0;
    if (clr_press) begin
      state_d  = ST_IDLE;
      sec_d    = '0;
      lap_d    = '0;
      ps_d     = '0;
      frozen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_press) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (ps_q == PS_LAST) begin
            ps_d   = '0;
            sec_d  = sec_inc;
            tick_d = 1'b1;
          end else begin
            ps_d = ps_q + 1'b1;
          end
          // Reaching the ceiling pauses with the prescaler already wrapped to zero.
          if ((ps_q == PS_LAST && sec_inc == SEC_MAX) || ss_press) state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (ss_press && sec_q != SEC_MAX) state_d = ST_RUNNING;
        end
        default: state_d = ST_IDLE;
      endcase
      // Freeze captures the pre-increment seconds value.
      if (lap_press && state_q != ST_IDLE) begin
        frozen_d = ~frozen_q;
        if (!frozen_q) lap_d = sec_q;
      end
    end
  end

  always_comb begin
    count      = frozen_q ? lap_q : sec_q;
    running    = (state_q == ST_RUNNING);
    lap_frozen = frozen_q;
    tick       = tick_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stopwatch_ctrl: scoreboard bench, CLK_HZ=4, MAX_COUNT=5 and 5999  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_ss = 1'b0, b_clr = 1'b0, b_lap = 1'b0;

  logic [12:0] cnt_a, cnt_b;
  logic        run_a, run_b, lap_a, lap_b, tk_a, tk_b;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(4), .CNT_W(13), .MAX_COUNT(5)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .btn_start_stop(b_ss), .btn_clear(b_clr), .btn_lap(b_lap),
    .count(cnt_a), .running(run_a), .lap_frozen(lap_a), .tick(tk_a)
  );

  stopwatch_ctrl #(.CLK_HZ(4), .CNT_W(13), .MAX_COUNT(5999)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .btn_start_stop(b_ss), .btn_clear(b_clr), .btn_lap(b_lap),
    .count(cnt_b), .running(run_b), .lap_frozen(lap_b), .tick(tk_b)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        sel;
    logic [12:0] cnt;
    logic        run;
    logic        lap;
    logic        tk;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  // Inputs are applied 1 time unit after a posedge and sampled at the next one.
  task automatic cycle(input logic ss, input logic clr, input logic lap);
    b_ss  = ss;
    b_clr = clr;
    b_lap = lap;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic sel, input logic [12:0] c, input logic r,
                     input logic l, input logic t);
    exp_t e;
    e.id  = 16'(step_id);
    e.sel = sel;
    e.cnt = c;
    e.run = r;
    e.lap = l;
    e.tk  = t;
    q.push_back(e);
    step_id++;
  endtask

  exp_t        m_e;
  logic [12:0] m_c;
  logic        m_r, m_l, m_t;

  always @(negedge clk) begin
    while (q.size() != 0) begin
      m_e = q.pop_front();
      m_c = m_e.sel ? cnt_b : cnt_a;
      m_r = m_e.sel ? run_b : run_a;
      m_l = m_e.sel ? lap_b : lap_a;
      m_t = m_e.sel ? tk_b  : tk_a;
      total++;
      if ({m_c, m_r, m_l, m_t} !== {m_e.cnt, m_e.run, m_e.lap, m_e.tk}) begin
        bad++;
        $display("FAIL chk%0d dut_%s: got count=%0d running=%b lap=%b tick=%b, want count=%0d running=%b lap=%b tick=%b",
                 m_e.id, m_e.sel ? "b" : "a", m_c, m_r, m_l, m_t,
                 m_e.cnt, m_e.run, m_e.lap, m_e.tk);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk(0, 0, 0, 0, 0);
    chk(1, 0, 0, 0, 0);
    rst_n = 1'b1;
    cycle(0, 0, 0);
    chk(0, 0, 0, 0, 0);

    // Start, tick on every 4th cycle
    cycle(1, 0, 0);
    chk(0, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0);
      chk(0, 13'(k / 4), 1'b1, 1'b0, (k % 4) == 0);
    end
    cycle(0, 1, 0);
    chk(0, 0, 0, 0, 0);

    // Pause preserves the partial second
    cycle(1, 0, 0);
    chk(0, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) cycle(0, 0, 0);
    chk(0, 1, 1, 0, 0);
    cycle(1, 0, 0);
    chk(0, 1, 0, 0, 0);
    for (int k = 0; k < 100; k++) cycle(0, 0, 0);
    chk(0, 1, 0, 0, 0);
    cycle(1, 0, 0);
    chk(0, 1, 1, 0, 0);
    cycle(0, 0, 0);
    chk(0, 1, 1, 0, 0);
    cycle(0, 0, 0);
    chk(0, 2, 1, 0, 1);
    cycle(0, 1, 0);
    chk(0, 0, 0, 0, 0);

    // Saturation at MAX_COUNT=5
    cycle(1, 0, 0);
    chk(0, 0, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 0, 0);
      chk(0, 13'(k / 4), k < 20, 1'b0, (k % 4) == 0);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0);
      chk(0, 5, 0, 0, 0);
    end
    cycle(1, 0, 0);
    chk(0, 5, 0, 0, 0);
    cycle(0, 0, 0);
    chk(0, 5, 0, 0, 0);
    cycle(0, 1, 0);
    chk(0, 0, 0, 0, 0);

    // Clear wins over start_stop; lap ignored in IDLE
    cycle(1, 0, 0);
    chk(0, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) cycle(0, 0, 0);
    chk(0, 1, 1, 0, 0);
    cycle(1, 1, 0);
    chk(0, 0, 0, 0, 0);
    cycle(0, 0, 0);
    chk(0, 0, 0, 0, 0);
    cycle(0, 0, 1);
    chk(0, 0, 0, 0, 0);
    cycle(0, 0, 0);

    // Button held through reset release, then reset mid-run
    rst_n = 1'b0;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0);
      chk(0, 0, 0, 0, 0);
    end
    cycle(0, 0, 0);
    chk(0, 0, 0, 0, 0);
    cycle(1, 0, 0);
    chk(0, 0, 1, 0, 0);
    cycle(0, 0, 1);
    chk(0, 0, 1, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk(0, 0, 1, 1, 0);
    rst_n = 1'b0;
    cycle(0, 0, 0);
    chk(0, 0, 0, 0, 0);
    chk(1, 0, 0, 0, 0);
    rst_n = 1'b1;
    cycle(0, 0, 0);
    chk(0, 0, 0, 0, 0);

    // Lap freeze/release on the MAX_COUNT=5999 instance
    cycle(1, 0, 0);
    chk(1, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0);
      chk(1, 13'(k / 4), 1'b1, 1'b0, (k % 4) == 0);
    end
    cycle(0, 0, 1);
    chk(1, 3, 1, 1, 0);
    for (int k = 14; k <= 28; k++) begin
      cycle(0, 0, 0);
      chk(1, 3, 1'b1, 1'b1, (k % 4) == 0);
    end
    cycle(0, 0, 1);
    chk(1, 7, 1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk(1, 7, 1, 0, 0);
    // Freeze on the same edge as a tick captures the pre-increment value
    cycle(0, 0, 1);
    chk(1, 7, 1, 1, 1);
    cycle(0, 0, 0);
    chk(1, 7, 1, 1, 0);
    cycle(0, 0, 1);
    chk(1, 8, 1, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
